// File: rtl/uart_ctrl.sv
// Parametrised UART: fractional baud generator, RX/TX engines, FIFOs, sticky errors.
// Optional UART_LOOPBACK_EN adds a loopback port routing ser_out into the receiver.
module uart_ctrl_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == CNT_W'(DEPTH));
    assign empty = (level == '0);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = empty ? '0 : mem[rp];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wp] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr_en)
                wp <= wp + AW'(1);
            if (rd_en)
                rp <= rp + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module uart_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ser_in,
    output logic              ser_out,
    input  logic [11:0]       baud_freq,
    input  logic [15:0]       baud_limit,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop,
    input  logic [DATA_W-1:0] tx_wdata,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic [CNT_W-1:0]  tx_level,
    output logic              tx_busy,
    output logic [DATA_W-1:0] rx_rdata,
    input  logic              rx_rd,
    output logic              rx_empty,
    output logic [CNT_W-1:0]  rx_level,
    output logic              err_frame,
    output logic              err_parity,
    output logic              err_overrun,
    input  logic              err_clr,
`ifdef UART_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              baud_clk
);
    localparam logic [2:0] LAST = 3'(DATA_W - 1);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PARITY, T_STOP1, T_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PARITY, R_STOP
    } rx_state_t;

    logic [15:0] acc;
    logic [16:0] nxt;
    logic        ce;

    assign nxt      = {1'b0, acc} + {5'b0, baud_freq};
    assign baud_clk = ce;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (baud_limit != '0 && nxt >= {1'b0, baud_limit}) begin
            acc <= 16'(nxt - {1'b0, baud_limit});
            ce  <= 1'b1;
        end else begin
            acc <= nxt[15:0];
            ce  <= 1'b0;
        end
    end

    logic [DATA_W-1:0] tx_head;
    logic              tx_empty;
    logic              tx_pop;
    logic              tx_last;
    tx_state_t         tx_state;
    logic [3:0]        tx_cnt;
    logic [2:0]        tx_bit;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_par;
    logic              tx_pen;
    logic              tx_two;
    logic              ser_q;

    uart_ctrl_fifo #(
        .W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_wr),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    // Chaining the next pop onto the final stop tick avoids an idle gap.
    assign tx_last = ce && tx_cnt == 4'd15 &&
                     ((tx_state == T_STOP1 && !tx_two) || tx_state == T_STOP2);
    assign tx_pop  = ce && !tx_empty && (tx_state == T_IDLE || tx_last);
    assign tx_busy = !tx_empty || tx_state != T_IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
            tx_two   <= 1'b0;
            ser_q    <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= T_START;
            tx_cnt   <= '0;
            tx_sh    <= tx_head;
            tx_par   <= parity_odd ? ~^tx_head : ^tx_head;
            tx_pen   <= parity_en;
            tx_two   <= two_stop;
            ser_q    <= 1'b0;
        end else if (ce) begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_cnt == 4'd15) begin
                unique case (tx_state)
                    T_IDLE: ;
                    T_START: begin
                        tx_state <= T_DATA;
                        tx_bit   <= '0;
                        ser_q    <= tx_sh[0];
                    end
                    T_DATA: begin
                        if (tx_bit == LAST) begin
                            tx_state <= tx_pen ? T_PARITY : T_STOP1;
                            ser_q    <= tx_pen ? tx_par : 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= tx_sh >> 1;
                            ser_q  <= tx_sh[1];
                        end
                    end
                    T_PARITY: begin
                        tx_state <= T_STOP1;
                        ser_q    <= 1'b1;
                    end
                    T_STOP1:
                        tx_state <= tx_two ? T_STOP2 : T_IDLE;
                    T_STOP2:
                        tx_state <= T_IDLE;
                    default:
                        tx_state <= T_IDLE;
                endcase
            end
        end
    end

    logic [1:0]        rx_sync;
    logic              rx_in;
    rx_state_t         rx_state;
    logic [3:0]        rx_cnt;
    logic [2:0]        rx_bit;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_pbit;
    logic              rx_pen;
    logic              rx_odd;
    logic              rx_push;
    logic              rx_full;
    logic              ev_frame;
    logic              ev_parity;
    logic              ev_overrun;

    always_ff @(posedge clock) begin
        if (reset)
            rx_sync <= 2'b11;
        else
            rx_sync <= {rx_sync[0], ser_in};
    end

`ifdef UART_LOOPBACK_EN
    assign rx_in   = loopback ? ser_q : rx_sync[1];
    assign ser_out = loopback ? 1'b1 : ser_q;
`else
    assign rx_in   = rx_sync[1];
    assign ser_out = ser_q;
`endif

    assign rx_push    = ce && rx_state == R_STOP && rx_cnt == 4'd15;
    assign ev_frame   = rx_push && !rx_in;
    assign ev_parity  = rx_push && rx_pen &&
                        (rx_pbit != (rx_odd ? ~^rx_sh : ^rx_sh));
    assign ev_overrun = rx_push && rx_full && !rx_rd;

    uart_ctrl_fifo #(
        .W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_sh),
        .pop   (rx_rd),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_pbit  <= 1'b0;
            rx_pen   <= 1'b0;
            rx_odd   <= 1'b0;
        end else if (ce) begin
            unique case (rx_state)
                R_IDLE: begin
                    if (!rx_in) begin
                        rx_state <= R_START;
                        rx_cnt   <= '0;
                        rx_pen   <= parity_en;
                        rx_odd   <= parity_odd;
                    end
                end
                R_START: begin
                    if (rx_cnt == 4'd7) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_in ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 4'd1;
                    end
                end
                R_DATA: begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15) begin
                        rx_sh <= {rx_in, rx_sh[DATA_W-1:1]};
                        if (rx_bit == LAST)
                            rx_state <= rx_pen ? R_PARITY : R_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end
                end
                R_PARITY: begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15) begin
                        rx_pbit  <= rx_in;
                        rx_state <= R_STOP;
                    end
                end
                R_STOP: begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15)
                        rx_state <= R_IDLE;
                end
                default:
                    rx_state <= R_IDLE;
            endcase
        end
    end

    // A set event outranks a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= ev_frame   | (err_frame   & ~err_clr);
            err_parity  <= ev_parity  | (err_parity  & ~err_clr);
            err_overrun <= ev_overrun | (err_overrun & ~err_clr);
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: directed TX bit checks plus an RX scoreboard.
// Loopback section builds only with UART_LOOPBACK_EN.
module tb_uart_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        ser_in;
    logic        ser_out;
    logic [11:0] baud_freq;
    logic [15:0] baud_limit;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
    logic [7:0]  tx_wdata;
    logic        tx_wr;
    logic        tx_full;
    logic [4:0]  tx_level;
    logic        tx_busy;
    logic [7:0]  rx_rdata;
    logic        rx_rd;
    logic        rx_empty;
    logic [4:0]  rx_level;
    logic        err_frame;
    logic        err_parity;
    logic        err_overrun;
    logic        err_clr;
    logic        baud_clk;
`ifdef UART_LOOPBACK_EN
    logic        loopback;
`endif

    int errors = 0;
    int checks = 0;
    int bit_clks = 64;
    logic [7:0] exp_q[$];

    uart_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .ser_in      (ser_in),
        .ser_out     (ser_out),
        .baud_freq   (baud_freq),
        .baud_limit  (baud_limit),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .two_stop    (two_stop),
        .tx_wdata    (tx_wdata),
        .tx_wr       (tx_wr),
        .tx_full     (tx_full),
        .tx_level    (tx_level),
        .tx_busy     (tx_busy),
        .rx_rdata    (rx_rdata),
        .rx_rd       (rx_rd),
        .rx_empty    (rx_empty),
        .rx_level    (rx_level),
        .err_frame   (err_frame),
        .err_parity  (err_parity),
        .err_overrun (err_overrun),
        .err_clr     (err_clr),
`ifdef UART_LOOPBACK_EN
        .loopback    (loopback),
`endif
        .baud_clk    (baud_clk)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic use_par,
                           input logic pbit, input logic stop_v,
                           input logic keep);
        if (keep)
            exp_q.push_back(d);
        ser_in = 1'b0;
        clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            ser_in = d[i];
            clks(bit_clks);
        end
        if (use_par) begin
            ser_in = pbit;
            clks(bit_clks);
        end
        ser_in = stop_v;
        clks(bit_clks);
        ser_in = 1'b1;
        clks(bit_clks);
    endtask

    task automatic rx_read();
        int n;
        logic [7:0] e;
        n = 0;
        while (rx_empty && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (rx_empty) begin
            check("rx_timeout", 32'd1, 32'd0);
        end else if (exp_q.size() == 0) begin
            check("rx_unexpected", {24'd0, rx_rdata}, 32'hffff_ffff);
        end else begin
            e = exp_q.pop_front();
            check("rx_data", {24'd0, rx_rdata}, {24'd0, e});
            rx_rd = 1'b1;
            @(negedge clock);
            rx_rd = 1'b0;
        end
    endtask

    task automatic tx_push(input logic [7:0] d);
        tx_wdata = d;
        tx_wr    = 1'b1;
        @(negedge clock);
        tx_wr    = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] a5;
        logic [9:0] frame;

        reset      = 1'b1;
        ser_in     = 1'b1;
        baud_freq  = 12'd0;
        baud_limit = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        tx_wdata   = 8'h00;
        tx_wr      = 1'b0;
        rx_rd      = 1'b0;
        err_clr    = 1'b0;
`ifdef UART_LOOPBACK_EN
        loopback   = 1'b0;
`endif
        clks(5);
        check("rst_ser_out", {31'd0, ser_out}, 32'd1);
        check("rst_flags", {26'd0, tx_full, tx_busy, rx_empty,
              err_frame, err_parity, err_overrun}, 32'b001000);
        check("rst_levels", {22'd0, tx_level, rx_level}, 32'd0);
        check("rst_baud_clk", {31'd0, baud_clk}, 32'd0);
        check("rst_rx_rdata", {24'd0, rx_rdata}, 32'd0);
        reset = 1'b0;

        baud_freq  = 12'd1;
        baud_limit = 16'd4;
        n = 0;
        while (!baud_clk && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("baud_first", {31'd0, baud_clk}, 32'd1);
        bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (baud_clk !== ((k % 4) == 0))
                bad++;
        end
        check("baud_period", bad, 0);

        a5 = 8'hA5;
        frame = {1'b1, a5, 1'b0};
        tx_push(a5);
        check("tx_busy_on", {31'd0, tx_busy}, 32'd1);
        n = 0;
        while (ser_out && n < 40) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (!ser_out && n < 200) begin
            n++;
            @(negedge clock);
        end
        check("tx_start_len", n, 64);
        clks(32);
        bad = 0;
        for (int i = 1; i < 10; i++) begin
            if (ser_out !== frame[i])
                bad++;
            if (i < 9)
                clks(64);
        end
        check("tx_a5_bits", bad, 0);
        check("tx_busy_stop", {31'd0, tx_busy}, 32'd1);
        clks(40);
        check("tx_busy_off", {31'd0, tx_busy}, 32'd0);

        parity_en = 1'b1;
        two_stop  = 1'b1;
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        rx_read();
        check("par_ok", {31'd0, err_parity}, 32'd0);
        send_rx(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        rx_read();
        check("par_bad", {31'd0, err_parity}, 32'd1);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        check("par_clr", {31'd0, err_parity}, 32'd0);

        parity_en = 1'b0;
        two_stop  = 1'b0;
        for (int i = 0; i < 17; i++)
            send_rx(8'(i * 13 + 7), 1'b0, 1'b0, 1'b1, i < 16);
        check("ovr_level", {27'd0, rx_level}, 32'd16);
        check("ovr_flag", {31'd0, err_overrun}, 32'd1);
        for (int i = 0; i < 16; i++)
            rx_read();
        check("ovr_drained", {31'd0, rx_empty}, 32'd1);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;

        baud_limit = 16'd8;
        clks(20);
        ser_in = 1'b0;
        clks(40);
        ser_in = 1'b1;
        clks(400);
        check("glitch_empty", {31'd0, rx_empty}, 32'd1);
        check("glitch_err", {30'd0, err_frame, err_parity}, 32'd0);
        baud_limit = 16'd4;
        clks(20);

        send_rx(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_read();
        check("frame_err", {31'd0, err_frame}, 32'd1);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        clks(200);

`ifdef UART_LOOPBACK_EN
        loopback   = 1'b1;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        clks(10);
        tx_push(8'h00);
        exp_q.push_back(8'h00);
        tx_push(8'hFF);
        exp_q.push_back(8'hFF);
        tx_push(8'h5A);
        exp_q.push_back(8'h5A);
        bad = 0;
        for (int k = 0; k < 2600; k++) begin
            @(negedge clock);
            if (ser_out !== 1'b1)
                bad++;
        end
        check("lb_ser_out_high", bad, 0);
        for (int i = 0; i < 3; i++)
            rx_read();
        check("lb_errors", {29'd0, err_frame, err_parity, err_overrun}, 32'd0);
        loopback = 1'b0;
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
